// File: rtl/mode_sequencer.sv
// Mode controller: debounces NEXT/PREV buttons, steps a wrapping mode register with optional
// auto-advance, and drives one-hot sub-block enables with a blanking gap after every change.
module mode_sequencer #(
  parameter int NUM_MODES    = 5,
  parameter int MODE_W       = 3,
  parameter int DEB_CYCLES   = 16,
  parameter int AUTO_CYCLES  = 50000000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_next,
  input  logic                 btn_prev,
  input  logic                 auto_en,
  output logic [MODE_W-1:0]    mode,
  output logic [NUM_MODES-1:0] enables,
  output logic                 blanking,
  output logic                 mode_change
);

  localparam int NB = 2;
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int AW = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  typedef enum logic {RUN, BLANK} state_t;

  // Button lanes: index 0 = NEXT, 1 = PREV.
  logic [NB-1:0]         raw, lvl, ev;
  logic [NB-1:0][1:0]    sync;
  logic [NB-1:0][DW-1:0] dcnt;

  assign raw = {btn_prev, btn_next};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      lvl  <= '0;
      ev   <= '0;
      dcnt <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        sync[i] <= {sync[i][0], raw[i]};
        ev[i]   <= 1'b0;
        if (sync[i][1] == lvl[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DW'(DEB_CYCLES - 1)) begin
          // Level accepted; only the rising flip produces an event.
          lvl[i]  <= sync[i][1];
          ev[i]   <= sync[i][1];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + DW'(1);
        end
      end
    end
  end

  state_t                state;
  logic [AW-1:0]         acnt;
  logic [BW-1:0]         bcnt;
  logic                  tick;
  logic                  next_ev, prev_ev, step_fwd, step_back;
  logic [MODE_W-1:0]     mode_inc, mode_dec, target;
  logic [NUM_MODES-1:0]  onehot;

  assign next_ev = ev[0];
  assign prev_ev = ev[1];
  // A tick is absorbed by any button event, including a cancelling NEXT+PREV pair.
  assign step_fwd  = (next_ev & ~prev_ev) | (tick & auto_en & ~next_ev & ~prev_ev);
  assign step_back = prev_ev & ~next_ev;
  assign onehot    = NUM_MODES'(1) << mode;

  always_comb begin
    mode_inc = (mode == MODE_W'(NUM_MODES - 1)) ? '0 : mode + MODE_W'(1);
    mode_dec = (mode == '0) ? MODE_W'(NUM_MODES - 1) : mode - MODE_W'(1);
    target   = step_back ? mode_dec : mode_inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      mode        <= '0;
      enables     <= NUM_MODES'(1);
      blanking    <= 1'b0;
      mode_change <= 1'b0;
      acnt        <= '0;
      bcnt        <= '0;
      tick        <= 1'b0;
    end else begin
      mode_change <= 1'b0;
      tick        <= 1'b0;
      case (state)
        RUN: begin
          if (!auto_en) begin
            acnt <= '0;
          end else if (acnt == AW'(AUTO_CYCLES - 1)) begin
            acnt <= '0;
            tick <= 1'b1;
          end else begin
            acnt <= acnt + AW'(1);
          end
          if (step_fwd || step_back) begin
            mode     <= target;
            enables  <= '0;
            blanking <= 1'b1;
            bcnt     <= '0;
            acnt     <= '0;
            state    <= BLANK;
          end
        end
        BLANK: begin
          acnt <= '0;
          if (bcnt == BW'(BLANK_CYCLES - 1)) begin
            enables     <= onehot;
            blanking    <= 1'b0;
            mode_change <= 1'b1;
            state       <= RUN;
          end else begin
            bcnt <= bcnt + BW'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
